// File: rtl/lift_controller.sv
`timescale 1ns/1ps
// Three-floor toy-lift controller: input synchronisers, homing, call latching and sweep scheduling.
// Define LIFT_DOOR_DWELL_EN to add a timed door dwell (DWELL_CYCLES) after every stop.
module lift_controller #(
   parameter int unsigned SYNC_STAGES  = 2
`ifdef LIFT_DOOR_DWELL_EN
   , parameter int unsigned DWELL_CYCLES = 50000000
`endif
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       bottom,
   input  logic       middle_minus,
   input  logic       middle_plus,
   input  logic       top,
   input  logic       call0,
   input  logic       call1,
   input  logic       call2,
   output logic       direction,
   output logic       enable,
   output logic [1:0] floor,
   output logic [2:0] pending
);

   localparam int unsigned IN_W = 7;

   typedef enum logic [2:0] {
      ST_HOMING,
      ST_IDLE,
      ST_MOVE_UP,
      ST_MOVE_DOWN,
      ST_ARRIVED
`ifdef LIFT_DOOR_DWELL_EN
      , ST_DWELL
`endif
   } state_t;

   state_t                           state;
   logic [IN_W-1:0]                  raw;
   logic [SYNC_STAGES-1:0][IN_W-1:0] sync_q;
   logic [IN_W-1:0]                  synced;
   logic                             at0, at1, at2, conflict;
   logic [2:0]                       calls, clr, pending_next;
   logic [1:0]                       sensed_floor;
   logic                             above, below;
   logic [1:0]                       prime_cnt;
   logic                             primed;

`ifdef LIFT_DOOR_DWELL_EN
   localparam int unsigned       DWELL_W    = 26;
   localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYCLES - 1);
   logic [DWELL_W-1:0]           dwell_cnt;
`endif

   function automatic logic [2:0] floor_bit(input logic [1:0] f);
      floor_bit = (f == 2'd3) ? 3'b000 : (3'b001 << f);
   endfunction

   // Synchronisers idle high so nothing looks asserted straight out of reset.
   assign raw = {call2, call1, call0, top, middle_plus, middle_minus, bottom};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) sync_q <= '1;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
   end

   assign synced   = sync_q[SYNC_STAGES-1];
   assign at0      = ~synced[0];
   assign at1      = ~synced[1] & ~synced[2];
   assign at2      = ~synced[3];
   assign calls    = ~synced[6:4];
   assign conflict = (at0 & at2) | (at0 & at1);
   assign primed   = (prime_cnt == 2'(SYNC_STAGES));

   always_comb begin
      sensed_floor = floor;
      if (at0)      sensed_floor = 2'd0;
      else if (at1) sensed_floor = 2'd1;
      else if (at2) sensed_floor = 2'd2;
   end

   // Outstanding calls relative to the confirmed floor.
   always_comb begin
      above = 1'b0;
      below = 1'b0;
      case (floor)
         2'd0:    above = |pending[2:1];
         2'd1:    begin above = pending[2]; below = pending[0]; end
         2'd2:    below = |pending[1:0];
         default: ;
      endcase
   end

   // Calls for the floor the lift is standing at are cleared; clear beats a new set.
   always_comb begin
      clr = 3'b000;
      case (state)
         ST_IDLE:    clr = floor_bit(floor);
         ST_ARRIVED: clr = floor_bit(sensed_floor);
`ifdef LIFT_DOOR_DWELL_EN
         ST_DWELL:   clr = floor_bit(floor);
`endif
         default:    ;
      endcase
      pending_next = (pending | calls) & ~clr;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= ST_HOMING;
         direction <= 1'b0;
         enable    <= 1'b1;
         floor     <= 2'b11;
         pending   <= 3'b000;
         prime_cnt <= 2'd0;
`ifdef LIFT_DOOR_DWELL_EN
         dwell_cnt <= '0;
`endif
      end else begin
         pending <= pending_next;
         if (!primed) prime_cnt <= prime_cnt + 2'd1;

         if (conflict) begin
            enable <= 1'b1;
            floor  <= 2'b11;
            state  <= ST_HOMING;
         end else begin
            case (state)
               // Motor stays off until the synchronisers hold real sensor values.
               ST_HOMING: begin
                  direction <= 1'b0;
                  if (at0) begin
                     enable <= 1'b1;
                     floor  <= 2'd0;
                     state  <= ST_IDLE;
                  end else begin
                     enable <= ~primed;
                  end
               end
               ST_IDLE: begin
                  enable <= 1'b1;
                  if (|(pending & floor_bit(floor))) begin
                     state <= ST_IDLE;
                  end else if (above && (direction || !below)) begin
                     direction <= 1'b1;
                     enable    <= 1'b0;
                     state     <= ST_MOVE_UP;
                  end else if (below) begin
                     direction <= 1'b0;
                     enable    <= 1'b0;
                     state     <= ST_MOVE_DOWN;
                  end
               end
               ST_MOVE_UP: begin
                  direction <= 1'b1;
                  enable    <= 1'b0;
                  if (at2) begin
                     enable <= 1'b1;
                     floor  <= 2'd2;
                     state  <= ST_ARRIVED;
                  end else if (at1) begin
                     floor <= 2'd1;
                     if (pending[1]) begin
                        enable <= 1'b1;
                        state  <= ST_ARRIVED;
                     end
                  end
               end
               ST_MOVE_DOWN: begin
                  direction <= 1'b0;
                  enable    <= 1'b0;
                  if (at0) begin
                     enable <= 1'b1;
                     floor  <= 2'd0;
                     state  <= ST_ARRIVED;
                  end else if (at1) begin
                     floor <= 2'd1;
                     if (pending[1]) begin
                        enable <= 1'b1;
                        state  <= ST_ARRIVED;
                     end
                  end
               end
               ST_ARRIVED: begin
                  enable <= 1'b1;
                  floor  <= sensed_floor;
`ifdef LIFT_DOOR_DWELL_EN
                  dwell_cnt <= DWELL_LOAD;
                  state     <= ST_DWELL;
`else
                  state     <= ST_IDLE;
`endif
               end
`ifdef LIFT_DOOR_DWELL_EN
               // A fresh call at this floor holds the doors open for another full dwell.
               ST_DWELL: begin
                  enable <= 1'b1;
                  if (|(calls & floor_bit(floor))) dwell_cnt <= DWELL_LOAD;
                  else if (dwell_cnt == '0)       state     <= ST_IDLE;
                  else                            dwell_cnt <= dwell_cnt - 1'b1;
               end
`endif
               default: begin
                  enable <= 1'b1;
                  state  <= ST_HOMING;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lift_controller.sv
`timescale 1ns/1ps
// Bench for lift_controller: a simple shaft plant drives the sensors and a floor-level
// sweep model predicts the sequence of stops for randomly chosen call sets.
module tb_lift_controller;

   localparam int unsigned SYNC = 2;
   localparam int          STEP = 8;    // clocks per shaft position; floors are 20 positions apart

   logic       clock = 1'b0;
   logic       reset, bottom, middle_minus, middle_plus, top, call0, call1, call2;
   logic       direction, enable;
   logic [1:0] floor;
   logic [2:0] pending;

   int  checks = 0;
   int  errors = 0;
   int  pos = 40;
   int  step_cnt = 0;
   bit  plant_on = 1'b0;
   bit  overshoot = 1'b0;
   bit  stop_ev = 1'b0;
   logic prev_en = 1'b1;
   logic prev_dir = 1'b0;
   int  stops[$];
   int  exp_q[$];
   int  mdl_floor = 0;
   bit  mdl_dir = 1'b0;

   lift_controller #(.SYNC_STAGES(SYNC)) dut (
      .clock(clock), .reset(reset),
      .bottom(bottom), .middle_minus(middle_minus), .middle_plus(middle_plus), .top(top),
      .call0(call0), .call1(call1), .call2(call2),
      .direction(direction), .enable(enable), .floor(floor), .pending(pending)
   );

   always #10 clock = ~clock;

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // One clock: sample just after the edge, watch reversals and stops, advance the shaft.
   task automatic tick();
      @(posedge clock);
      #1;
      stop_ev = 1'b0;
      if (reset) begin
         prev_en  = enable;
         prev_dir = direction;
         step_cnt = 0;
         return;
      end
      if (direction !== prev_dir) chk("reversal_motor_off", 32'(prev_en), 32'd1);
      if (prev_en === 1'b0 && enable === 1'b1) begin
         stop_ev = 1'b1;
         stops.push_back((pos % 20 == 0) ? pos / 20 : 9);
      end
      prev_en  = enable;
      prev_dir = direction;
      if (plant_on) begin
         if (enable === 1'b0) begin
            step_cnt++;
            if (step_cnt >= STEP) begin
               step_cnt = 0;
               pos += (direction === 1'b1) ? 1 : -1;
            end
         end else begin
            step_cnt = 0;
         end
         if (pos < 0 || pos > 40) begin
            overshoot = 1'b1;
            pos = (pos < 0) ? 0 : 40;
         end
         bottom       = !(pos == 0);
         middle_minus = !(pos >= 19 && pos <= 20);
         middle_plus  = !(pos >= 20 && pos <= 21);
         top          = !(pos == 40);
      end
   endtask

   task automatic pulse(input logic [2:0] m, input int len);
      call0 = !m[0];
      call1 = !m[1];
      call2 = !m[2];
      repeat (len) tick();
      call0 = 1'b1;
      call1 = 1'b1;
      call2 = 1'b1;
   endtask

   task automatic wait_stop(input string tag);
      int n = 0;
      while (!stop_ev && n < 4000) begin
         tick();
         n++;
      end
      chk(tag, 32'(stop_ev), 32'd1);
   endtask

   task automatic wait_pos(input int target, input string tag);
      int n = 0;
      while (pos != target && n < 4000) begin
         tick();
         n++;
      end
      chk(tag, 32'(pos), 32'(target));
   endtask

   task automatic wait_settle(input string tag);
      int quiet = 0;
      int n = 0;
      while (quiet < 12 && n < 4000) begin
         tick();
         n++;
         if (enable === 1'b1 && pending === 3'b000) quiet++;
         else quiet = 0;
      end
      chk(tag, 32'(quiet >= 12), 32'd1);
   endtask

   // Floor-level sweep model: list the floors the lift should stop at for a call set.
   task automatic plan_stops(input logic [2:0] calls);
      logic [2:0] p;
      int  f, nxt;
      bit  above, below;
      p = calls;
      f = mdl_floor;
      p[f] = 1'b0;
      exp_q.delete();
      while (p != 3'b000) begin
         above = 1'b0;
         below = 1'b0;
         nxt = f;
         for (int i = 0; i < 3; i++) begin
            if (p[i] && i > f) above = 1'b1;
            if (p[i] && i < f) below = 1'b1;
         end
         if (above && (mdl_dir || !below)) begin
            mdl_dir = 1'b1;
            for (int i = 2; i > f; i--) if (p[i]) nxt = i;
         end else begin
            mdl_dir = 1'b0;
            for (int i = 0; i < f; i++) if (p[i]) nxt = i;
         end
         exp_q.push_back(nxt);
         p[nxt] = 1'b0;
         f = nxt;
      end
      mdl_floor = f;
   endtask

   task automatic run_txn(input logic [2:0] mask);
      logic [2:0] cur, rest;
      cur  = mask & (3'b001 << mdl_floor);
      rest = mask & ~cur;
      plan_stops(mask);
      stops.delete();
      if (cur != 3'b000) begin
         pulse(cur, 3);
         repeat (5) tick();
      end
      if (rest != 3'b000) pulse(rest, 3);
      wait_settle("txn_settle");
      chk("txn_stop_count", 32'(stops.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         if (i < stops.size()) chk("txn_stop_floor", 32'(stops[i]), 32'(exp_q[i]));
      chk("txn_final_floor", 32'(floor), 32'(mdl_floor));
      chk("txn_pending_clear", 32'(pending), 32'd0);
   endtask

   initial begin
      int  n;
      bit  ok;
      logic d0;

      reset = 1'b1;
      bottom = 1'b1; middle_minus = 1'b1; middle_plus = 1'b1; top = 1'b0;
      call0 = 1'b1; call1 = 1'b1; call2 = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      chk("reset_direction", 32'(direction), 32'd0);
      chk("reset_enable", 32'(enable), 32'd1);
      chk("reset_floor", 32'(floor), 32'd3);
      chk("reset_pending", 32'(pending), 32'd0);

      // Homing from the top of the shaft.
      @(negedge clock);
      reset = 1'b0;
      prev_en = enable;
      prev_dir = direction;
      ok = 1'b1;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (i >= 2 * SYNC + 2 && (enable !== 1'b0 || direction !== 1'b0)) ok = 1'b0;
      end
      chk("homing_motor_down", 32'(ok), 32'd1);
      bottom = 1'b0;
      top = 1'b1;
      n = 0;
      while (enable !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("homing_stop_latency", 32'(n <= SYNC + 1), 32'd1);
      chk("homing_floor", 32'(floor), 32'd0);
      pos = 0;
      step_cnt = 0;
      plant_on = 1'b1;
      mdl_floor = 0;
      mdl_dir = 1'b0;

      // Call to the top floor passes the middle without stopping.
      pulse(3'b100, 5);
      chk("up_pending", 32'(pending), 32'd4);
      chk("up_direction", 32'(direction), 32'd1);
      chk("up_enable", 32'(enable), 32'd0);
      stops.delete();
      wait_pos(21, "up_reach_middle");
      chk("up_floor_middle", 32'(floor), 32'd1);
      chk("up_no_middle_stop", 32'(stops.size()), 32'd0);
      wait_stop("up_stop_top");
      chk("up_stop_pos", 32'(pos), 32'd40);
      repeat (2) tick();
      chk("up_floor_top", 32'(floor), 32'd2);
      chk("up_pending_clear", 32'(pending), 32'd0);

      // Back down to floor 0.
      pulse(3'b001, 3);
      wait_stop("down_stop");
      chk("down_stop_pos", 32'(pos), 32'd0);
      repeat (2) tick();
      chk("down_floor", 32'(floor), 32'd0);

      // Middle intercept on the way up, then a late call below forces a reversal at the top.
      pulse(3'b100, 3);
      wait_pos(10, "icpt_reach_10");
      pulse(3'b010, 3);
      wait_stop("icpt_stop");
      chk("icpt_stop_pos", 32'(pos), 32'd20);
      tick();
      chk("icpt_floor", 32'(floor), 32'd1);
      chk("icpt_pending", 32'(pending), 32'd4);
      n = 1;
      while (enable !== 1'b0 && n < 100) begin
         tick();
         n++;
      end
`ifdef LIFT_DOOR_DWELL_EN
      chk("icpt_resume", 32'(n < 100), 32'd1);
`else
      chk("icpt_resume_one_idle", 32'(n), 32'd2);
`endif
      chk("icpt_resume_up", 32'(direction), 32'd1);
      wait_pos(25, "rev_reach_25");
      pulse(3'b001, 3);
      tick();
      chk("rev_pending", 32'(pending), 32'd5);
      wait_stop("rev_stop_top");
      chk("rev_stop_pos", 32'(pos), 32'd40);
      tick();
      chk("rev_floor_top", 32'(floor), 32'd2);
      chk("rev_pending_after_top", 32'(pending), 32'd1);
      n = 0;
      while (enable !== 1'b0 && n < 100) begin
         tick();
         n++;
      end
      chk("rev_direction_down", 32'(direction), 32'd0);
      wait_stop("rev_stop_bottom");
      chk("rev_bottom_pos", 32'(pos), 32'd0);
      tick();
      chk("rev_floor_bottom", 32'(floor), 32'd0);
      mdl_floor = 0;
      mdl_dir = 1'b0;

      // A call for the floor the lift is idling at is absorbed without moving.
      ok = 1'b1;
      d0 = direction;
      call0 = 1'b0;
      repeat (5) begin
         tick();
         if (enable !== 1'b1 || pending !== 3'b000 || direction !== d0) ok = 1'b0;
      end
      call0 = 1'b1;
      repeat (4) begin
         tick();
         if (enable !== 1'b1 || pending !== 3'b000 || direction !== d0) ok = 1'b0;
      end
      chk("curfloor_no_motion", 32'(ok), 32'd1);

      // Random call sets against the sweep model.
      repeat (14) run_txn(3'($urandom_range(1, 7)));
      run_txn(3'b001);

      // Asynchronous reset in the middle of an upward run.
      pulse(3'b100, 3);
      wait_pos(5, "rst_reach_5");
      @(posedge clock);
      #5;
      reset = 1'b1;
      #1;
      chk("rst_async_enable", 32'(enable), 32'd1);
      chk("rst_async_pending", 32'(pending), 32'd0);
      chk("rst_async_floor", 32'(floor), 32'd3);
      chk("rst_async_direction", 32'(direction), 32'd0);
      repeat (3) tick();
      @(negedge clock);
      reset = 1'b0;
      repeat (2) tick();
      chk("rst_floor_unknown", 32'(floor), 32'd3);
      stops.delete();
      wait_stop("rst_rehome_stop");
      chk("rst_rehome_pos", 32'(pos), 32'd0);
      tick();
      chk("rst_rehome_floor", 32'(floor), 32'd0);
      chk("rst_rehome_pending", 32'(pending), 32'd0);

      chk("plant_no_overshoot", 32'(overshoot), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lift_controller.md
Name: lift_controller

Overview:
- Synthesisable three-floor lift controller for the DE0 toy-lift lab.
- Consumes the active-low position sensors (bottom, middle_minus, middle_plus, top) and active-low call buttons (call0..call2).
- Drives the motor through direction and active-low enable.
- Homes on startup, latches calls, and serves them with a direction-preserving sweep policy.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on every asynchronous input; legal range 2..3.
- DWELL_CYCLES, 50000000, clock cycles the lift waits at a served floor; used only when the dwell feature is compiled in; 26-bit counter.

Ports:
- clock  input  1  system clock, 50 MHz; the period must be much shorter than 1 us.
- reset  input  1  asynchronous, active-high reset.
- bottom  input  1  active-low; lift is at floor 0.
- middle_minus  input  1  active-low lower middle sensor.
- middle_plus  input  1  active-low upper middle sensor.
- top  input  1  active-low; lift is at floor 2.
- call0, call1, call2  input  1 each  active-low call button for floors 0, 1 and 2.
- direction  output  1  1 = up, 0 = down.
- enable  output  1  active-low motor enable; 0 = motor runs.
- floor  output  2  last confirmed floor, 0..2; 3 = unknown.
- pending  output  3  latched calls, bit n is floor n.

Behaviour:
- Clocking: one clock domain; reset is asynchronous and active-high; all outputs are registered.
- Reset values: direction=0, enable=1, floor=2'b11, pending=3'b000. State = HOMING. Synchroniser flops reset to 1 (inactive).
- Input sync: all seven inputs pass through SYNC_STAGES flops. Everything below uses the synchronised values. Calls and sensors are interpreted active-low.
- At-floor decode: at0 = !bottom_s; at2 = !top_s; at1 = !middle_minus_s && !middle_plus_s (both low at once).
- Call latch: pending[n] is set on any cycle callN_s=0. It is cleared in the cycle the lift is stopped (ARRIVED) at floor n. If set and clear coincide for the current floor while stopped, clear wins.
- HOMING:
  - direction=0, enable=0.
  - When at0 is seen: enable=1, floor=0, go to IDLE. Calls still latch during HOMING.
  - If at0 is already true on entry, stop immediately; the motor never runs.
- IDLE (enable=1): with F = floor,
  - pending[F] set -> clear it and stay.
  - Otherwise a pending floor above F and (direction=1, or no pending floor below F) -> MOVE_UP.
  - Otherwise a pending floor below F -> MOVE_DOWN.
  - Otherwise stay.
- MOVE_UP (direction=1, enable=0):
  - Passing at1 sets floor=1.
  - Stop (-> ARRIVED) at at1 if pending[1], or at at2.
  - The at2 stop is unconditional: a hard safety stop, whatever pending holds.
- MOVE_DOWN (direction=0, enable=0): mirror of MOVE_UP; unconditional stop at at0.
- ARRIVED:
  - enable=1.
  - Set floor to the sensed floor and clear that pending bit.
  - Next cycle -> IDLE, or -> DWELL if that feature is compiled in.
- Stop latency: at most SYNC_STAGES+1 clocks from the sensor edge to enable=1. This is far below one 1 us lift step, so the lift never overshoots a floor.
- Reversal rule: direction may change only in a cycle where enable has been 1 for at least one full cycle. The output never switches from up to down while the motor is enabled.
- Sensor conflict (at0 and at2 together, or at0 with at1): force enable=1 and go to HOMING with floor=3.
- Reset mid-motion: enable goes to 1 asynchronously, pending is cleared, and the controller re-homes.

Optional Feature:
- Macro LIFT_DOOR_DWELL_EN.
- Defined: after ARRIVED, the controller enters state DWELL with enable=1. A counter loads DWELL_CYCLES-1 and decrements to 0, then goes to IDLE. Calls latch during DWELL. A call for the current floor during DWELL is cleared and restarts the counter.
- Undefined: no DWELL state and no counter logic; ARRIVED goes straight to IDLE.

Test Plan:
- Homing: release reset with top=0 and other sensors high; drive bottom=0 after 200 cycles -> enable=0/direction=0 throughout, enable=1 and floor=0 within SYNC_STAGES+1 cycles of bottom=0.
- Up call past middle: from floor 0 idle, pulse call2=0 for 5 cycles; pass middle (both middle low for 50 cycles) -> pending=3'b100, direction=1, enable=0, floor becomes 1 without stopping, stop on top=0, pending=0, floor=2.
- Middle intercept: while moving up from floor 0 with pending=3'b100, pulse call1 before middle -> stops at at1, floor=1, pending=3'b100, then resumes up after one idle cycle (or after the dwell).
- Current-floor call: idle at floor 1, pulse call1 -> pending[1] clears, enable stays 1, direction unchanged.
- Reversal: at floor 1 moving up toward 2 with pending=3'b101 -> stops at 2, enable=1 for ≥1 cycle before direction=0, then serves floor 0.
- Async reset while moving: assert reset mid-cycle during MOVE_UP -> enable=1 before the next clock edge, pending=0, floor=3, HOMING after release.
